// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - fixed-latency 256-bit line memory endpoint for the cache pmem_* port
// Optional range checking and error reporting are enabled by defining PMEM_RANGE_CHECK_EN.
module pmem_line_responder #(
   parameter int s_offset = 5,
   parameter int s_line   = 256,
   parameter int s_mindex = 6,
   parameter int LATENCY  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pmem_address,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              pmem_error
);

   localparam int DEPTH = 2 ** s_mindex;
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_next;
   logic                r_op_read;
   logic [s_mindex-1:0] r_index;
   logic [s_line-1:0]   r_wdata;
   logic                r_oob;
   logic [s_line-1:0]   r_rdata;
   logic [s_line-1:0]   r_mem [DEPTH];

   logic                w_req;
   logic                w_oob;
   logic                w_load_rdata;
   logic [s_mindex-1:0] w_rd_index;
   logic                w_rd_oob;

   assign w_req = pmem_read | pmem_write;

`ifdef PMEM_RANGE_CHECK_EN
   logic r_err;
   assign w_oob      = |pmem_address[31:s_offset+s_mindex];
   assign pmem_error = (r_state == ST_RESP) & r_err;
`else
   assign w_oob      = 1'b0;
   assign pmem_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      pmem_resp  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (LATENCY == 1) begin
                  w_next = ST_RESP;
               end else begin
                  w_next     = ST_WAIT;
                  w_cnt_next = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) w_next = ST_RESP;
            else             w_cnt_next = r_cnt - 1'b1;
         end
         ST_RESP: begin
            pmem_resp = 1'b1;
            w_next    = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // With LATENCY==1 the read data is fetched in the same edge the request is latched.
   always_comb begin
      w_load_rdata = 1'b0;
      w_rd_index   = r_index;
      w_rd_oob     = r_oob;
      if (r_state == ST_IDLE) begin
         w_load_rdata = (w_next == ST_RESP) & pmem_read;
         w_rd_index   = pmem_address[s_offset +: s_mindex];
         w_rd_oob     = w_oob;
      end else if (r_state == ST_WAIT) begin
         w_load_rdata = (w_next == ST_RESP) & r_op_read;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op_read <= 1'b0;
         r_index   <= '0;
         r_wdata   <= '0;
         r_oob     <= 1'b0;
`ifdef PMEM_RANGE_CHECK_EN
         r_err     <= 1'b0;
`endif
      end else if (r_state == ST_IDLE && w_req) begin
         r_op_read <= pmem_read;
         r_index   <= pmem_address[s_offset +: s_mindex];
         r_wdata   <= pmem_wdata;
         r_oob     <= w_oob;
`ifdef PMEM_RANGE_CHECK_EN
         r_err     <= w_oob | (pmem_read & pmem_write);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_load_rdata) begin
         r_rdata <= w_rd_oob ? '0 : r_mem[w_rd_index];
      end
   end

   assign pmem_rdata = r_rdata;

   // Writes commit on the edge leaving RESP; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (r_state == ST_RESP && !r_op_read && !r_oob) begin
         r_mem[r_index] <= r_wdata;
      end
   end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Line-granular physical-memory responder that sits on the memory side of the cache's `pmem_*` interface, which carries 256-bit lines. It accepts one read or write line request at a time, waits a programmable number of cycles, then commits the write or returns the line, and pulses `pmem_resp`. It is synthesizable and backed by an internal line array. It serves as the memory endpoint for cache bring-up and as a stand-in for the cacheline adaptor plus DRAM model.

## Interface
- `s_offset`, 5, byte-offset bits per line; `pmem_address[s_offset-1:0]` ignored
- `s_line`, 256, line width in bits
- `s_mindex`, 6, line-index bits of backing store (2**s_mindex lines)
- `LATENCY`, 4, cycles from request sample to `pmem_resp`; legal range ≥1
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  reset, synchronous, active-low
- `pmem_address`  input  32  line address from cache
- `pmem_read`  input  1  read request, held until `pmem_resp`
- `pmem_write`  input  1  write request, held until `pmem_resp`
- `pmem_wdata`  input  s_line  write line
- `pmem_rdata`  output  s_line  read line, registered
- `pmem_resp`  output  1  one-cycle completion pulse
- `pmem_error`  output  1  error qualifier, valid only with `pmem_resp` (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `pmem_read|pmem_write` is high, latch `op`, index = `pmem_address[s_offset +: s_mindex]`, `pmem_wdata`, and a range flag.
  - `op` = read if `pmem_read` is high. When both `pmem_read` and `pmem_write` are high, the request is treated as a read and the write data is discarded.
  - Next state: RESP if LATENCY==1; otherwise WAIT with the counter loaded to LATENCY-2.
- WAIT: counter decrements each cycle. At 0, go to RESP. Input changes are ignored, because all request fields were latched.
- RESP:
  - `pmem_resp`=1 for exactly one cycle, then return to IDLE.
  - Read: `pmem_rdata` loaded with `mem[index]` on the edge entering RESP.
  - Write: `mem[index]` ← latched wdata on the edge leaving RESP.
- Counter width: `$clog2(LATENCY)` with a minimum of 1. No wrap is possible.
- Address bits above `s_offset+s_mindex` are ignored unless `PMEM_RANGE_CHECK_EN` is defined; without it, addresses alias modulo the store size.

## Timing
- A request high in cycle 0 (IDLE) gives `pmem_resp` high in cycle LATENCY.
- The initiator deasserts the request in the cycle after `pmem_resp`. If a request is still high in the IDLE cycle after RESP, it is accepted as a new request.
- Back-to-back: one idle cycle minimum, so requests are spaced LATENCY+1 cycles apart.
- `pmem_rdata` holds its last read value until the next read response. Writes do not change it.
- Read-after-write to the same index returns the new data. The write commits before IDLE is re-entered.
- Reset values: state IDLE, `pmem_resp`=0, `pmem_error`=0, `pmem_rdata`=0, counter 0, all lines 0.
- Reset during WAIT or RESP: the request is abandoned, no `pmem_resp` is issued, and a pending write is not committed.

## Configuration
- `PMEM_RANGE_CHECK_EN` defined:
  - Any set bit in `pmem_address[31:s_offset+s_mindex]` marks the request out of range.
  - The response keeps normal latency, with `pmem_error`=1 in the RESP cycle.
  - Out-of-range read returns all zeros. Out-of-range write is dropped.
  - A request with both read and write high also sets `pmem_error`.
- Undefined: the range check is removed, `pmem_error` is tied to 0, and addresses alias.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, then release. Required: `pmem_resp`=0, `pmem_rdata`=0, and a read of 0x00000040 returns 0.
- Write then read, LATENCY=4: write 0x00000060 with `{8{32'hDEADBEEF}}` gives `pmem_resp` exactly in cycle 4. A read of 0x00000060 issued in the next cycle returns `{8{32'hDEADBEEF}}` with `pmem_resp` 4 cycles later.
- Offset ignored and aliasing (macro off): write 0x0000007F, then read 0x00000060 returns the same line. Read 0x00000860 aliases to index 3, returns the same line, and `pmem_error`=0.
- Simultaneous request: `pmem_read`=`pmem_write`=1 at 0x20 with wdata 0xFF.. gives a read response with old data, and the line is unchanged. With the macro on, `pmem_error`=1.
- Reset mid-op: start a write of 0x1234 to 0x80, pull `rst` low in cycle 2. Required: no `pmem_resp`, and a subsequent read of 0x80 returns 0.
- Range check (macro on, s_mindex=6): write to 0x00000800 gives `pmem_resp` with `pmem_error`=1. A read of 0x00000000 still returns its prior contents, and a read of 0x800 returns 0 with `pmem_error`=1.
